final_soc_sw_debounce_irq: RTL

Avalon-MM slave controller for the 8-bit board switch input port. It synchronizes and debounces each switch and captures rising edges per bit. It raises a maskable level interrupt to the Nios II. It occupies the switch PIO slot on the system interconnect, with a 4-word register map.

---
 rtl/final_soc_pio_pkg.sv | 11 +
 rtl/final_soc_sw_debounce_irq_if.sv | 21 ++
 rtl/final_soc_sw_debounce_bit.sv | 62 ++++++
 rtl/final_soc_sw_debounce_irq.sv | 102 ++++++++++
 4 files changed

// File: rtl/final_soc_pio_pkg.sv
// Shared definitions for the switch PIO slave: register word addresses and bus width.
package final_soc_pio_pkg;

    localparam int RDATA_W = 32;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_THRESH = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_EDGE   = 2'd3;

endpackage

// File: rtl/final_soc_sw_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the switch PIO: the interconnect is the master side.
interface final_soc_sw_debounce_irq_if;
    import final_soc_pio_pkg::*;

    logic [1:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [RDATA_W-1:0] writedata;
    logic [RDATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/final_soc_sw_debounce_bit.sv
// One switch input: 2-FF synchronizer, tick-based debounce counter and the debounced bit.
// Besides the debounced bit it flags the cycle whose clock edge makes the bit rise,
// so the edge-capture register can set on that very edge.
module final_soc_sw_debounce_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [CNT_W-1:0] threshold,
    input  logic             raw_in,
    output logic             debounced,
    output logic             rising
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchronize, then only accept a new level after it has disagreed for more than threshold ticks.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (threshold == '0) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q >= threshold) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rising = db_d & ~db_q;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign debounced = db_q;

endmodule

// File: rtl/final_soc_sw_debounce_irq.sv
// Switch PIO slave: debounced switch state, threshold and mask registers,
// rising-edge capture with write-1-to-clear, and a registered maskable level irq.
module final_soc_sw_debounce_irq
    import final_soc_pio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE   = 50000,
    parameter int CNT_W      = 8,
    parameter int DEF_THRESH = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    final_soc_sw_debounce_irq_if.slave  bus,
    input  logic [DATA_W-1:0]           in_port,
    output logic                        irq
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [DATA_W-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]  edge_q, edge_d;
    logic               irq_q, irq_d;
    logic [RDATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0]  db;
    logic [DATA_W-1:0]  rise;
    logic [DATA_W-1:0]  clr;
    logic               wr_en;
    logic               unused_wdata;

    // Upper write-data bits beyond the register widths carry no meaning.
    assign unused_wdata = &{1'b0, bus.writedata};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            final_soc_sw_debounce_bit #(
                .CNT_W (CNT_W)
            ) u_bit (
                .clk       (clk),
                .reset_n   (reset_n),
                .tick      (tick),
                .threshold (thresh_q),
                .raw_in    (in_port[gi]),
                .debounced (db[gi]),
                .rising    (rise[gi])
            );
        end
    endgenerate

    // Next-state: prescaler, register writes, edge capture (set beats clear), irq and the read mux.
    always_comb begin
        tick     = (pre_q == PRE_LAST);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        wr_en    = bus.chipselect & ~bus.write_n;
        thresh_d = thresh_q;
        mask_d   = mask_q;
        clr      = '0;
        if (wr_en) begin
            case (bus.address)
                REG_THRESH: thresh_d = bus.writedata[CNT_W-1:0];
                REG_MASK:   mask_d   = bus.writedata[DATA_W-1:0];
                REG_EDGE:   clr      = bus.writedata[DATA_W-1:0];
                default:    ;
            endcase
        end
        edge_d = (edge_q & ~clr) | rise;
        irq_d  = |(edge_q & mask_q);
        case (bus.address)
            REG_DATA:   rdata_d = RDATA_W'(db);
            REG_THRESH: rdata_d = RDATA_W'(thresh_q);
            REG_MASK:   rdata_d = RDATA_W'(mask_q);
            default:    rdata_d = RDATA_W'(edge_q);
        endcase
    end

    // Register bank with asynchronous active-low reset; threshold comes up at its default.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q    <= '0;
            thresh_q <= CNT_W'(DEF_THRESH);
            mask_q   <= '0;
            edge_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            pre_q    <= pre_d;
            thresh_q <= thresh_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule
